rsa_modexp_sequencer: RTL and testbench

- Parametrised control sequencer for the Montgomery-based RSA modular exponentiation datapath (right-to-left binary method).
- Drives the MMM core and operand/result registers through three phases: map into the Montgomery domain, one multiply round per exponent bit, remap out.
- Differences from the fixed-sequence controller:
  - start/busy/eoc handshake, with restart after completion.
  - Runtime exponent length.
  - Configurable MMM latency.
  - Synchronous abort.

---
 rtl/rsa_pkg.sv | 33 +++
 rtl/rsa_phase_counter.sv | 34 +++
 rtl/rsa_modexp_sequencer.sv | 173 +++++++++++++++++
 tb/tb_rsa_modexp_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA modular-exponentiation sequencer.
package rsa_pkg;

  // Sequencer states: map into Montgomery domain, multiply rounds, remap out.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE_MAP,
    ST_MAP,
    ST_POST_MAP,
    ST_PRE_MMM,
    ST_MMM,
    ST_POST_MMM,
    ST_PRE_REMAP,
    ST_REMAP,
    ST_POST_REMAP,
    ST_DONE
  } state_e;

  // Operand mux encodings for sel1.
  localparam logic [1:0] SEL1_MAP   = 2'b00;
  localparam logic [1:0] SEL1_MMM   = 2'b01;
  localparam logic [1:0] SEL1_REMAP = 2'b10;

  // Ceiling log2, never below 1 so it can size a vector.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/rsa_phase_counter.sv
// Up-counter with synchronous clear, increment and terminal-count compare.
module rsa_phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] tc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_i);

endmodule

// File: rtl/rsa_modexp_sequencer.sv
// Control sequencer for a Montgomery-based right-to-left binary modexp datapath.
module rsa_modexp_sequencer
  import rsa_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter int  EXP_WIDTH  = WIDTH + 2,
  parameter int  MMM_CYCLES = WIDTH + 2,
  localparam int LEN_W      = clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 abort,
  input  logic [EXP_WIDTH-1:0] expE,
  input  logic [LEN_W-1:0]     exp_len,
  output logic                 rst_mmm,
  output logic                 ld_a,
  output logic                 ld_r,
  output logic                 lock1,
  output logic                 lock2,
  output logic [1:0]           sel1,
  output logic                 sel2,
  output logic                 busy,
  output logic                 eoc,
  output logic [LEN_W-1:0]     round_idx
);

  localparam int STEP_W = clog2(MMM_CYCLES + 1);

  state_e               state_q, state_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [LEN_W-1:0]     len_q, len_d;

  logic              step_clr, step_inc, step_tc;
  logic [STEP_W-1:0] step_cnt;
  logic              round_clr, round_inc, round_tc;
  logic [LEN_W-1:0]  round_cnt;
  logic              last_round;

  // Step counter paces each MMM operation phase (MMM_CYCLES+1 cycles).
  rsa_phase_counter #(.W(STEP_W)) u_step_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr_i (step_clr),
    .inc_i (step_inc),
    .tc_i  (STEP_W'(MMM_CYCLES)),
    .cnt_o (step_cnt),
    .tc_o  (step_tc)
  );

  // Round counter tracks processed exponent bits against the captured length.
  rsa_phase_counter #(.W(LEN_W)) u_round_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr_i (round_clr),
    .inc_i (round_inc),
    .tc_i  (len_q),
    .cnt_o (round_cnt),
    .tc_o  (round_tc)
  );

  // In POST_MMM the branch looks at the round count as it will be after this round.
  assign last_round = ((round_cnt + LEN_W'(1)) == len_q);
  assign round_idx  = round_cnt;

  // Next-state, counter control and per-state output decode.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    len_d     = len_q;
    step_clr  = 1'b0;
    step_inc  = 1'b0;
    round_clr = 1'b0;
    round_inc = 1'b0;
    rst_mmm   = 1'b0;
    ld_a      = 1'b0;
    ld_r      = 1'b0;
    lock1     = 1'b0;
    lock2     = 1'b0;
    sel1      = SEL1_MAP;
    sel2      = 1'b0;
    busy      = 1'b0;
    eoc       = 1'b0;

    // Abort overrides both start and the enable freeze.
    if (abort) begin
      state_d   = ST_IDLE;
      exp_d     = '0;
      step_clr  = 1'b1;
      round_clr = 1'b1;
    end else if (ena) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_PRE_MAP;
            exp_d     = expE;
            len_d     = (exp_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : exp_len;
            round_clr = 1'b1;
          end
        end
        ST_PRE_MAP:   begin step_clr = 1'b1; state_d = ST_MAP; end
        ST_MAP:       begin step_inc = 1'b1; if (step_tc) state_d = ST_POST_MAP; end
        ST_POST_MAP:  state_d = round_tc ? ST_PRE_REMAP : ST_PRE_MMM;
        ST_PRE_MMM:   begin step_clr = 1'b1; state_d = ST_MMM; end
        ST_MMM:       begin step_inc = 1'b1; if (step_tc) state_d = ST_POST_MMM; end
        ST_POST_MMM: begin
          round_inc = 1'b1;
          exp_d     = exp_q >> 1;
          state_d   = last_round ? ST_PRE_REMAP : ST_PRE_MMM;
        end
        ST_PRE_REMAP:  begin step_clr = 1'b1; state_d = ST_REMAP; end
        ST_REMAP:      begin step_inc = 1'b1; if (step_tc) state_d = ST_POST_REMAP; end
        ST_POST_REMAP: state_d = ST_DONE;
        default:       state_d = ST_IDLE;
      endcase
    end

    case (state_q)
      ST_PRE_MAP, ST_MAP, ST_POST_MAP: begin
        rst_mmm = 1'b1;
        lock1   = 1'b1;
        lock2   = 1'b1;
        sel1    = SEL1_MAP;
        ld_a    = (state_q != ST_POST_MAP);
        ld_r    = (state_q == ST_POST_MAP);
        busy    = 1'b1;
      end
      ST_PRE_MMM, ST_MMM, ST_POST_MMM: begin
        rst_mmm = 1'b1;
        lock1   = exp_q[0];
        lock2   = 1'b1;
        sel1    = SEL1_MMM;
        sel2    = 1'b1;
        ld_a    = (state_q == ST_PRE_MMM);
        ld_r    = (state_q == ST_POST_MMM);
        busy    = 1'b1;
      end
      ST_PRE_REMAP, ST_REMAP, ST_POST_REMAP: begin
        rst_mmm = 1'b1;
        lock1   = 1'b1;
        sel1    = SEL1_REMAP;
        sel2    = 1'b1;
        ld_a    = (state_q == ST_PRE_REMAP);
        ld_r    = (state_q == ST_POST_REMAP);
        busy    = 1'b1;
      end
      ST_DONE: begin
        rst_mmm = 1'b1;
        lock1   = 1'b1;
        sel1    = SEL1_REMAP;
        sel2    = 1'b1;
        ld_r    = 1'b1;
        eoc     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, exponent and length registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// Directed self-checking bench for rsa_modexp_sequencer (WIDTH=8, EXP_WIDTH=10, MMM_CYCLES=10).
module tb_rsa_modexp_sequencer;

  localparam int LIMIT = 1000;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic       start;
  logic       abort;
  logic [9:0] expE;
  logic [3:0] exp_len;
  logic       rst_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, eoc;
  logic [1:0] sel1;
  logic [3:0] round_idx;
  logic [13:0] outs;

  int total = 0;
  int bad   = 0;

  int         cyc;
  logic [9:0] lmask;
  logic [9:0] vis;

  rsa_modexp_sequencer #(
    .WIDTH      (8),
    .EXP_WIDTH  (10),
    .MMM_CYCLES (10)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .start     (start),
    .abort     (abort),
    .expE      (expE),
    .exp_len   (exp_len),
    .rst_mmm   (rst_mmm),
    .ld_a      (ld_a),
    .ld_r      (ld_r),
    .lock1     (lock1),
    .lock2     (lock2),
    .sel1      (sel1),
    .sel2      (sel2),
    .busy      (busy),
    .eoc       (eoc),
    .round_idx (round_idx)
  );

  assign outs = {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc, round_idx};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [9:0] e, input logic [3:0] l);
    expE    = e;
    exp_len = l;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Walks one busy period, counting busy cycles and recording which rounds ran
  // and which had lock1 set. Optionally pulses start, stalls, or aborts in a round.
  task automatic measure(input int pulse_at, input int stall_round, input logic stall_lock,
                         input int abort_round,
                         output int cycles, output logic [9:0] lm, output logic [9:0] vs);
    bit stalled;
    logic [13:0] frozen;
    stalled = 1'b0;
    cycles  = 0;
    lm      = '0;
    vs      = '0;
    frozen  = {1'b1, 1'b0, 1'b0, stall_lock, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 4'(stall_round)};
    for (int guard = 0; guard < LIMIT && busy; guard++) begin
      cycles++;
      start = (cycles == pulse_at);
      if (start) begin
        expE    = 10'h3FF;
        exp_len = 4'd10;
      end
      if (sel1 == 2'b01) begin
        vs[round_idx] = 1'b1;
        if (lock1) lm[round_idx] = 1'b1;
      end
      if (sel1 == 2'b01 && !ld_a && !ld_r && int'(round_idx) == stall_round && !stalled) begin
        stalled = 1'b1;
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          cycles++;
          check("stall_freeze", 32'(outs), 32'(frozen));
        end
        ena = 1'b1;
      end
      if (sel1 == 2'b01 && !ld_a && !ld_r && int'(round_idx) == abort_round) begin
        abort = 1'b1;
        ena   = 1'b0;
        step();
        check("abort_idle", 32'(outs), 32'd0);
        abort = 1'b0;
        ena   = 1'b1;
        break;
      end
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    rstb    = 1'b0;
    ena     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    expE    = '0;
    exp_len = '0;
    #1;
    check("reset_outs", 32'(outs), 32'd0);
    step();
    step();
    rstb = 1'b1;
    step();
    step();
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_eoc", 32'(eoc), 32'd0);

    // Full run: bits 0,1,3 set.
    start_run(10'b0000001011, 4'd10);
    check("premap_ld_a", 32'(ld_a), 32'd1);
    check("premap_outs", 32'(outs), 32'(14'b1_1_0_1_1_00_0_1_0_0000));
    measure(-1, -1, 1'b0, -1, cyc, lmask, vis);
    check("full_busy_cycles", 32'(cyc), 32'd156);
    check("full_lock_mask", 32'(lmask), 32'h00B);
    check("full_rounds", 32'(vis), 32'h3FF);
    check("full_eoc", 32'(eoc), 32'd1);
    check("full_sel1", 32'(sel1), 32'd2);
    check("done_lock2", 32'(lock2), 32'd0);
    check("done_ld_r", 32'(ld_r), 32'd1);

    // Restart straight from DONE with a new exponent.
    start_run(10'b0000000110, 4'd3);
    check("restart_eoc", 32'(eoc), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_ld_a", 32'(ld_a), 32'd1);
    check("restart_sel1", 32'(sel1), 32'd0);
    measure(-1, -1, 1'b0, -1, cyc, lmask, vis);
    check("restart_busy_cycles", 32'(cyc), 32'd65);
    check("restart_lock_mask", 32'(lmask), 32'h006);
    check("restart_rounds", 32'(vis), 32'h007);

    // Zero length, with a start pulse while busy that must be ignored.
    start_run(10'h3FF, 4'd0);
    measure(3, -1, 1'b0, -1, cyc, lmask, vis);
    check("zero_busy_cycles", 32'(cyc), 32'd26);
    check("zero_no_mmm", 32'(vis), 32'd0);
    check("zero_eoc", 32'(eoc), 32'd1);

    // Enable low in DONE holds eoc and ignores start.
    ena   = 1'b0;
    start = 1'b1;
    step();
    step();
    step();
    check("frozen_done_eoc", 32'(eoc), 32'd1);
    check("frozen_done_busy", 32'(busy), 32'd0);
    start = 1'b0;
    ena   = 1'b1;
    step();

    // Length above EXP_WIDTH is clamped to 10.
    start_run(10'h000, 4'd15);
    measure(-1, -1, 1'b0, -1, cyc, lmask, vis);
    check("clamp_busy_cycles", 32'(cyc), 32'd156);
    check("clamp_rounds", 32'(vis), 32'h3FF);
    check("clamp_lock_mask", 32'(lmask), 32'h000);

    // Five-cycle stall in the MMM phase of round 4 (bit 4 of 0x00B is 0).
    start_run(10'b0000001011, 4'd10);
    measure(-1, 4, 1'b0, -1, cyc, lmask, vis);
    check("stall_busy_cycles", 32'(cyc), 32'd161);
    check("stall_lock_mask", 32'(lmask), 32'h00B);
    check("stall_eoc", 32'(eoc), 32'd1);

    // Abort in round 4 (with ena low), then a fresh 3-bit run.
    start_run(10'b0000001011, 4'd10);
    measure(-1, -1, 1'b0, 4, cyc, lmask, vis);
    step();
    check("after_abort_outs", 32'(outs), 32'd0);
    start_run(10'b1111111101, 4'd3);
    measure(-1, -1, 1'b0, -1, cyc, lmask, vis);
    check("post_abort_busy_cycles", 32'(cyc), 32'd65);
    check("post_abort_lock_mask", 32'(lmask), 32'h005);
    check("post_abort_rounds", 32'(vis), 32'h007);

    // Abort beats start in DONE.
    start = 1'b1;
    abort = 1'b1;
    step();
    check("abort_over_start", 32'(outs), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    step();
    check("idle_stays", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a run.
    start_run(10'b0000001011, 4'd10);
    for (int k = 0; k < 20; k++) step();
    check("midrun_busy", 32'(busy), 32'd1);
    #2;
    rstb = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs), 32'd0);
    step();
    rstb = 1'b1;
    step();
    step();
    check("after_reset_busy", 32'(busy), 32'd0);
    check("after_reset_eoc", 32'(eoc), 32'd0);
    start_run(10'b0000001011, 4'd3);
    measure(-1, -1, 1'b0, -1, cyc, lmask, vis);
    check("recover_busy_cycles", 32'(cyc), 32'd65);
    check("recover_lock_mask", 32'(lmask), 32'h003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
